layer_frame_ctl: RTL
====================

// Module: layer_frame_ctl
// PURPOSE
//  Frame sequencer for the NeoPixel output path: on start, fetches pixel bytes from the pixel RAM,
//  serialises them MSB-first onto the LED data line using the T0H/T0L/T1H/T1L timing counts, then
//  emits the reset gap. Sits between the timing configuration registers, the pixel RAM and the output pin.
// PARAMETERS
//  LED_NUM  64                       LEDs per frame; frame = LED_NUM*3 bytes
//  ADDR_W   $clog2(LED_NUM*3)        pixel RAM byte-address width
// PORTS
//  clk_in           in   1       system clock
//  rst_n_in         in   1       asynchronous reset, active-low
//  start_in         in   1       frame start request; accepted only in IDLE
//  t0h_cnt_in       in   8       '0' bit high-phase count
//  t0l_cnt_in       in   8       '0' bit low-phase count
//  t1h_cnt_in       in   8       '1' bit high-phase count
//  t1l_cnt_in       in   8       '1' bit low-phase count
//  rst_cnt_in       in   16      reset-gap count
//  ram_rd_en_out    out  1       pixel RAM read strobe
//  ram_rd_addr_out  out  ADDR_W  pixel RAM byte address
//  ram_rd_data_in   in   8       pixel RAM data, valid 1 cycle after ram_rd_en_out
//  bit_out          out  1       LED serial data line
//  busy_out         out  1       high from start acceptance until done_out cycle inclusive
//  done_out         out  1       one-cycle pulse at frame end
// BEHAVIOUR
//  - Reset: state IDLE; bit_out=0, busy_out=0, done_out=0, ram_rd_en_out=0, ram_rd_addr_out=0, counters 0.
//  - FSM: IDLE -> FETCH -> LOAD -> BIT_H <-> BIT_L ... -> RST -> IDLE.
//  - IDLE: start_in=1 -> latch all five counts into shadow regs, busy_out=1, go FETCH. start_in ignored elsewhere.
//  - Counts written during a frame have no effect until the next start.
//  - FETCH (1 cyc): rd_en=1, addr=0. LOAD (1 cyc): shift reg <= ram_rd_data_in, bit index=7.
//  - Phase length = count+1 cycles (count 0 -> 1 cycle). BIT_H drives 1 for t{b}h+1, BIT_L drives 0 for
//    t{b}l+1 cycles, b = current bit. After BIT_L of bit 0 of last byte -> RST.
//  - Prefetch: on the first cycle of BIT_H for bit 7 of byte k (k<LED_NUM*3-1): rd_en=1, addr=k+1;
//    data captured next cycle into nxt_byte. End of bit 0 BIT_L loads shift reg from nxt_byte:
//    no idle cycles between bytes; bit_out continuous across byte boundaries.
//  - rd_en is high exactly LED_NUM*3 cycles per frame; addresses strictly 0..LED_NUM*3-1, no wrap.
//  - RST: bit_out=0 for rst_cnt+1 cycles; last RST cycle -> IDLE and done_out=1 that cycle (busy_out still 1).
//  - start_in on the done_out cycle is ignored; accepted from the next (IDLE) cycle.
//  - Frame length = 2 + sum(bit phases) + rst_cnt+1 cycles.
//  - Async reset mid-frame: immediate return to IDLE with reset values; no done_out.
// CONFIGURATION
//  - OUT_INV_EN defined: bit_out is inverted at the pin register (idle/RST level 1, high phase 0),
//    including the reset value (1). Undefined: non-inverted as above. Nothing else changes.
// STRUCTURE
//  - Package layer_frame_pkg: state enum (IDLE,FETCH,LOAD,BIT_H,BIT_L,RST), CNT_W=16 phase-counter width.
//  - Sub-module layer_phase_tmr: loadable 16-bit down counter (load, value, expire pulse); one instance
//    shared by BIT_H, BIT_L and RST.
//  - bit_out registered; no combinational path from inputs to any output.
// TESTING
//  - LED_NUM=1, bytes {80,00,FF}, t0h=1,t0l=2,t1h=3,t1l=0, rst=5: bit_out = 1-bit: H4 L1; 0-bits H2 L3;
//    24 bits in order, 6-cycle RST, done_out once, total cycles checked.
//  - Prefetch: LED_NUM=2, all counts 0: rd_en pulses at addr 0..5, no gap between bytes, 48 bits 1H/1L.
//  - Counts changed mid-frame (t1h 3->9): current frame keeps 3; next start uses 9.
//  - start_in held high continuously: frames back-to-back with exactly one IDLE cycle between done_out
//    and next FETCH; pulses during busy ignored.
//  - rst_n_in asserted mid BIT_H: bit_out=0, busy_out=0 immediately; no done_out; new start works.
//  - OUT_INV_EN build: repeat first test, bit_out is the exact complement, reset level 1.

Source files
------------

// File: rtl/layer_frame_pkg.sv
// Shared definitions for the NeoPixel frame sequencer.
//   CNT_W       width of the shared phase timer
//   St*         FSM state encodings (plain constants for legacy tools)
//   cnt_cfg_t   shadow copy of the five timing counts, latched at frame start
//   phase_len   selects the '0' or '1' count for the current bit
package layer_frame_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StBitH  = 3'd3;
  localparam logic [2:0] StBitL  = 3'd4;
  localparam logic [2:0] StRst   = 3'd5;

  typedef struct packed {
    logic [7:0]  t0h;
    logic [7:0]  t0l;
    logic [7:0]  t1h;
    logic [7:0]  t1l;
    logic [15:0] rst;
  } cnt_cfg_t;

  function automatic logic [CNT_W-1:0] phase_len(input logic       b,
                                                 input logic [7:0] cnt0,
                                                 input logic [7:0] cnt1);
    return CNT_W'(b ? cnt1 : cnt0);
  endfunction

endpackage

// File: rtl/layer_frame_ctl_if.sv
// Pixel RAM read port between the frame sequencer and the pixel RAM.
//   rd_en    read strobe (master -> RAM)
//   rd_addr  byte address (master -> RAM)
//   rd_data  read data, valid one cycle after rd_en (RAM -> master)
interface layer_frame_ctl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/layer_phase_tmr.sv
// Loadable down counter timing one output phase.
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   load_i            load value_i this cycle (phase starts next cycle)
//   value_i           phase count; the phase lasts value_i+1 cycles
//   expire_o          high on the last cycle of the phase (counter at zero)
module layer_phase_tmr
  import layer_frame_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/layer_frame_ctl.sv
// NeoPixel frame sequencer: on start, reads LED_NUM*3 pixel bytes and serialises them MSB-first
// with per-bit high/low phase counts, then emits the reset gap.
//   clk_in, rst_n_in     clock, asynchronous active-low reset
//   start_in             frame request, accepted only when idle
//   t0h/t0l/t1h/t1l/rst  timing counts, latched at start acceptance
//   ram_if               pixel RAM read port (master side)
//   bit_out              registered LED data line
//   busy_out             high from start acceptance through the done_out cycle
//   done_out             one-cycle pulse on the last reset-gap cycle
// Build option: OUT_INV_EN inverts bit_out at the pin register, reset level included.
module layer_frame_ctl
  import layer_frame_pkg::*;
#(
  parameter int unsigned LED_NUM = 64,
  parameter int unsigned ADDR_W  = $clog2(LED_NUM * 3)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic [7:0]          t0h_cnt_in,
  input  logic [7:0]          t0l_cnt_in,
  input  logic [7:0]          t1h_cnt_in,
  input  logic [7:0]          t1l_cnt_in,
  input  logic [15:0]         rst_cnt_in,
  layer_frame_ctl_if.master   ram_if,
  output logic                bit_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam logic [ADDR_W-1:0] LastByte = ADDR_W'(LED_NUM * 3 - 1);
`ifdef OUT_INV_EN
  localparam logic OutInv = 1'b1;
`else
  localparam logic OutInv = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  cnt_cfg_t          cfg_q, cfg_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        nxt_q, nxt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              pend_q;
  logic              bit_q, bit_d;
  logic              busy_q;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_expire;
  logic              cur_bit;

  assign cur_bit = sh_q[bit_idx_q];

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    sh_d      = sh_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          cfg_d = '{t0h: t0h_cnt_in, t0l: t0l_cnt_in, t1h: t1h_cnt_in,
                    t1l: t1l_cnt_in, rst: rst_cnt_in};
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        sh_d      = ram_if.rd_data;
        bit_idx_d = 3'd7;
        byte_d    = '0;
        state_d   = StBitH;
        tmr_load  = 1'b1;
        tmr_value = phase_len(sh_d[7], cfg_q.t0h, cfg_q.t1h);
      end
      StBitH: begin
        if (tmr_expire) begin
          state_d   = StBitL;
          tmr_load  = 1'b1;
          tmr_value = phase_len(cur_bit, cfg_q.t0l, cfg_q.t1l);
        end
      end
      StBitL: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
            state_d   = StBitH;
            tmr_value = phase_len(sh_q[bit_idx_d], cfg_q.t0h, cfg_q.t1h);
          end else if (byte_q == LastByte) begin
            state_d   = StRst;
            tmr_value = cfg_q.rst;
          end else begin
            // Byte boundary: prefetched byte is already in nxt_q, so no bubble.
            sh_d      = nxt_q;
            bit_idx_d = 3'd7;
            byte_d    = byte_q + ADDR_W'(1);
            state_d   = StBitH;
            tmr_value = phase_len(nxt_q[7], cfg_q.t0h, cfg_q.t1h);
          end
        end
      end
      StRst: begin
        if (tmr_expire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reads: byte 0 in FETCH, byte k+1 on the first high cycle of bit 7 of byte k.
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    if (state_d == StFetch) begin
      rd_en_d = 1'b1;
      addr_d  = '0;
    end else if (state_d == StBitH && state_q != StBitH && bit_idx_d == 3'd7 &&
                 byte_d != LastByte) begin
      rd_en_d = 1'b1;
      addr_d  = byte_d + ADDR_W'(1);
    end

    nxt_d = pend_q ? ram_if.rd_data : nxt_q;
    bit_d = OutInv ^ (state_d == StBitH);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      cfg_q     <= '0;
      sh_q      <= '0;
      nxt_q     <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      pend_q    <= 1'b0;
      bit_q     <= OutInv;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      sh_q      <= sh_d;
      nxt_q     <= nxt_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      // Prefetch data arrives the cycle after the strobe; FETCH data goes straight to sh.
      pend_q    <= rd_en_q && (state_q == StBitH);
      bit_q     <= bit_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  layer_phase_tmr u_tmr (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  assign ram_if.rd_en   = rd_en_q;
  assign ram_if.rd_addr = addr_q;
  assign bit_out        = bit_q;
  assign busy_out       = busy_q;
  // Derived from registered state and counter only.
  assign done_out       = (state_q == StRst) && tmr_expire;

endmodule
